gate_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one two-input `gate` instance (ports x, y, z) among N_REQ requesters.
- Accepts one operand pair per transaction, drives the shared gate, waits GATE_LAT cycles, captures z and returns it to the granted requester with a done pulse.
- Sits between requester blocks and the single `gate` datapath; the gate itself is unchanged.

---
 rtl/gate_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_gate_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : gate_arbiter
// Description : Round-robin arbiter/sequencer sharing one two-input gate
//               (x, y -> z) among N_REQ requesters. One operand pair per
//               transaction; z is sampled GATE_LAT cycles after the operands
//               are driven and returned with a done pulse.
//               Optional macro GATE_ARB_STATS_EN adds saturating per-requester
//               grant counters on output grant_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module gate_arbiter #(
    parameter int N_REQ    = 4,
    parameter int ID_W     = 2,
    parameter int GATE_LAT = 1
`ifdef GATE_ARB_STATS_EN
    ,
    parameter int CNT_W    = 16
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ-1:0]   req_x,
    input  logic [N_REQ-1:0]   req_y,
    output logic [N_REQ-1:0]   ack,
    output logic [N_REQ-1:0]   done,
    output logic               rsp_z,
    output logic               gate_x,
    output logic               gate_y,
    input  logic               gate_z,
    output logic               busy,
    output logic [ID_W-1:0]    grant_id
`ifdef GATE_ARB_STATS_EN
    ,
    output logic [N_REQ*CNT_W-1:0] grant_cnt
`endif
);

    // Two-state sequencer encoding
    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_WAIT = 1'b1;

    // GATE_LAT <= 15, so the wait counter never needs more than 4 bits
    localparam logic [3:0] c_LAT_LAST = 4'(GATE_LAT - 1);
    localparam logic [ID_W-1:0] c_LAST_ID = ID_W'(N_REQ - 1);

    logic [0:0]       state_q,    state_d;
    logic [3:0]       cnt_q,      cnt_d;
    logic [ID_W-1:0]  rr_ptr_q,   rr_ptr_d;
    logic [ID_W-1:0]  grant_id_q, grant_id_d;
    logic [N_REQ-1:0] ack_q,      ack_d;
    logic [N_REQ-1:0] done_q,     done_d;
    logic             rsp_z_q,    rsp_z_d;
    logic             gate_x_q,   gate_x_d;
    logic             gate_y_q,   gate_y_d;
    logic             busy_q,     busy_d;

    logic [ID_W-1:0]  win_idx;
    logic             grant_now;

    // Pick the lowest set request at or above rr_ptr; if none, the lowest below it
    always_comb begin
        win_idx = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (req[j] && (j < int'(rr_ptr_q))) begin
                win_idx = ID_W'(j);
            end
        end
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (req[j] && (j >= int'(rr_ptr_q))) begin
                win_idx = ID_W'(j);
            end
        end
    end

    // Sequencer next-state: grant in IDLE, count latency and return z in WAIT
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        ack_d      = '0;
        done_d     = '0;
        rsp_z_d    = rsp_z_q;
        gate_x_d   = gate_x_q;
        gate_y_d   = gate_y_q;
        busy_d     = busy_q;
        grant_now  = 1'b0;
        case (state_q)
            c_IDLE: begin
                if (|req) begin
                    grant_now        = 1'b1;
                    grant_id_d       = win_idx;
                    gate_x_d         = req_x[win_idx];
                    gate_y_d         = req_y[win_idx];
                    ack_d[win_idx]   = 1'b1;
                    busy_d           = 1'b1;
                    cnt_d            = '0;
                    state_d          = c_WAIT;
                end
            end
            c_WAIT: begin
                // Requests are not looked at while a transaction is in flight
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == c_LAT_LAST) begin
                    rsp_z_d              = gate_z;
                    done_d[grant_id_q]   = 1'b1;
                    busy_d               = 1'b0;
                    cnt_d                = '0;
                    // The requester just served drops to lowest priority
                    rr_ptr_d             = (grant_id_q == c_LAST_ID) ? '0
                                                                     : grant_id_q + ID_W'(1);
                    state_d              = c_IDLE;
                end
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= c_IDLE;
            cnt_q      <= '0;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            ack_q      <= '0;
            done_q     <= '0;
            rsp_z_q    <= 1'b0;
            gate_x_q   <= 1'b0;
            gate_y_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            ack_q      <= ack_d;
            done_q     <= done_d;
            rsp_z_q    <= rsp_z_d;
            gate_x_q   <= gate_x_d;
            gate_y_q   <= gate_y_d;
            busy_q     <= busy_d;
        end
    end

    assign ack      = ack_q;
    assign done     = done_q;
    assign rsp_z    = rsp_z_q;
    assign gate_x   = gate_x_q;
    assign gate_y   = gate_y_q;
    assign busy     = busy_q;
    assign grant_id = grant_id_q;

`ifdef GATE_ARB_STATS_EN
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_stats
        logic [CNT_W-1:0] gcnt_q, gcnt_d;

        // Count acks issued to this requester, holding at all-ones
        always_comb begin
            gcnt_d = gcnt_q;
            if (grant_now && (win_idx == ID_W'(gi)) && (gcnt_q != {CNT_W{1'b1}})) begin
                gcnt_d = gcnt_q + CNT_W'(1);
            end
        end

        // Per-requester grant counter register
        always_ff @(posedge clk) begin
            if (rst) begin
                gcnt_q <= '0;
            end else begin
                gcnt_q <= gcnt_d;
            end
        end

        assign grant_cnt[gi*CNT_W +: CNT_W] = gcnt_q;
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_gate_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_gate_arbiter
// Description : Self-checking bench for gate_arbiter (N_REQ=4, GATE_LAT=2,
//               gate model z = x & y) against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_arbiter;

    localparam int N_REQ    = 4;
    localparam int ID_W     = 2;
    localparam int GATE_LAT = 2;
`ifdef GATE_ARB_STATS_EN
    localparam int CNT_W    = 2;
`endif
    localparam int CNT_MAX  = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [3:0]       req = '0;
    logic [3:0]       req_x = '0;
    logic [3:0]       req_y = '0;
    logic [3:0]       ack;
    logic [3:0]       done;
    logic             rsp_z;
    logic             gate_x;
    logic             gate_y;
    logic             gate_z;
    logic             busy;
    logic [1:0]       grant_id;
`ifdef GATE_ARB_STATS_EN
    logic [7:0]       grant_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // The shared gate under arbitration
    assign gate_z = gate_x & gate_y;

`ifdef GATE_ARB_STATS_EN
    gate_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W), .GATE_LAT(GATE_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .req(req), .req_x(req_x), .req_y(req_y),
        .ack(ack), .done(done), .rsp_z(rsp_z), .gate_x(gate_x), .gate_y(gate_y),
        .gate_z(gate_z), .busy(busy), .grant_id(grant_id), .grant_cnt(grant_cnt)
    );
`else
    gate_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W), .GATE_LAT(GATE_LAT)) dut (
        .clk(clk), .rst(rst), .req(req), .req_x(req_x), .req_y(req_y),
        .ack(ack), .done(done), .rsp_z(rsp_z), .gate_x(gate_x), .gate_y(gate_y),
        .gate_z(gate_z), .busy(busy), .grant_id(grant_id)
    );
`endif

    // ---------------- reference model (transaction level) ----------------
    // m_left = cycles still to go in the current transaction (0 = idle).
    logic [3:0] exp_ack = '0, exp_done = '0;
    logic       exp_rsp = 1'b0, exp_gx = 1'b0, exp_gy = 1'b0, exp_busy = 1'b0;
    logic [1:0] exp_gid = '0;
    int         m_rr = 0, m_left = 0;
    int         m_cnt [N_REQ];

    logic [3:0] n_ack, n_done;
    logic       n_rsp, n_gx, n_gy, n_busy;
    logic [1:0] n_gid;
    int         n_rr, n_left, w;
    int         n_cnt [N_REQ];

    function automatic int pick(input logic [3:0] r, input int rr);
        int idx;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (rr + k) % N_REQ;
            if (r[idx]) return idx;
        end
        return 0;
    endfunction

    always_comb begin
        n_ack = '0; n_done = '0; n_rsp = exp_rsp; n_gx = exp_gx; n_gy = exp_gy;
        n_busy = exp_busy; n_gid = exp_gid; n_rr = m_rr; n_left = m_left; w = 0;
        n_cnt = m_cnt;
        if (rst) begin
            n_rsp = 1'b0; n_gx = 1'b0; n_gy = 1'b0; n_busy = 1'b0; n_gid = '0;
            n_rr = 0; n_left = 0;
            for (int i = 0; i < N_REQ; i++) n_cnt[i] = 0;
        end else if (m_left > 0) begin
            n_left = m_left - 1;
            if (m_left == 1) begin
                n_rsp = exp_gx & exp_gy;
                n_done[exp_gid] = 1'b1;
                n_busy = 1'b0;
                n_rr = (int'(exp_gid) + 1) % N_REQ;
            end
        end else if (req != 4'b0000) begin
            w = pick(req, m_rr);
            n_gid = 2'(w);
            n_gx = req_x[w];
            n_gy = req_y[w];
            n_ack[w] = 1'b1;
            n_busy = 1'b1;
            n_left = GATE_LAT;
            if (n_cnt[w] < CNT_MAX) n_cnt[w] = n_cnt[w] + 1;
        end
    end

    always @(posedge clk) begin
        exp_ack <= n_ack; exp_done <= n_done; exp_rsp <= n_rsp; exp_gx <= n_gx;
        exp_gy <= n_gy; exp_busy <= n_busy; exp_gid <= n_gid; m_rr <= n_rr;
        m_left <= n_left; m_cnt <= n_cnt;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1; req = '0;
        tick();
        rst = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            req = 4'($urandom); req_x = 4'($urandom); req_y = 4'($urandom);
            tick();
            checks++;
            if ({ack, done, rsp_z, gate_x, gate_y, busy, grant_id} !== 15'd0) begin
                errors++;
                $display("FAIL reset_outputs cyc=%0d got=%b want=0", c,
                         {ack, done, rsp_z, gate_x, gate_y, busy, grant_id});
            end
        end
        req = '0; rst = 1'b0;
        tick();
        checks++;
        if ({ack, done, busy} !== 9'd0) begin
            errors++;
            $display("FAIL reset_release got ack=%b done=%b busy=%b want all 0", ack, done, busy);
        end
    endtask

    task automatic test_single();
        req = 4'b0001; req_x = {3'($urandom), 1'b1}; req_y = {3'($urandom), 1'b1};
        tick();
        checks++;
        if (ack !== 4'b0001 || gate_x !== 1'b1 || gate_y !== 1'b1 || busy !== 1'b1 || grant_id !== 2'd0) begin
            errors++;
            $display("FAIL single_grant got ack=%b gx=%b gy=%b busy=%b gid=%0d want 0001 1 1 1 0",
                     ack, gate_x, gate_y, busy, grant_id);
        end
        req = '0;
        tick();
        checks++;
        if (ack !== 4'b0000 || done !== 4'b0000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_wait got ack=%b done=%b busy=%b want 0000 0000 1", ack, done, busy);
        end
        tick();
        checks++;
        if (done !== 4'b0001 || rsp_z !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_done got done=%b rsp_z=%b busy=%b want 0001 1 0", done, rsp_z, busy);
        end
        tick();
        checks++;
        if (done !== 4'b0000 || busy !== 1'b0 || rsp_z !== 1'b1 || grant_id !== 2'd0) begin
            errors++;
            $display("FAIL single_after got done=%b busy=%b rsp_z=%b gid=%0d want 0000 0 1 0",
                     done, busy, rsp_z, grant_id);
        end
    endtask

    task automatic test_round_robin();
        int got;
        int last;
        got = 0; last = -1;
        pulse_reset();
        req = 4'hF; req_x = 4'($urandom); req_y = 4'($urandom);
        for (int c = 0; c < 20 && got < 5; c++) begin
            tick();
            checks++;
            if ({ack, done, busy, grant_id, rsp_z, gate_x, gate_y} !==
                {exp_ack, exp_done, exp_busy, exp_gid, exp_rsp, exp_gx, exp_gy}) begin
                errors++;
                $display("FAIL rr_model cyc=%0d got=%b want=%b", c,
                         {ack, done, busy, grant_id, rsp_z, gate_x, gate_y},
                         {exp_ack, exp_done, exp_busy, exp_gid, exp_rsp, exp_gx, exp_gy});
            end
            if (ack != 4'b0000) begin
                checks++;
                if (int'(grant_id) != got % 4) begin
                    errors++;
                    $display("FAIL rr_order n=%0d got=%0d want=%0d", got, grant_id, got % 4);
                end
                if (last >= 0) begin
                    checks++;
                    if (c - last != GATE_LAT + 1) begin
                        errors++;
                        $display("FAIL rr_spacing got=%0d want=%0d", c - last, GATE_LAT + 1);
                    end
                end
                last = c; got++;
                req_x = 4'($urandom); req_y = 4'($urandom);
            end
        end
        checks++;
        if (got != 5) begin
            errors++;
            $display("FAIL rr_count got=%0d want=5", got);
        end
        req = '0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if ({done, rsp_z, busy} !== {exp_done, exp_rsp, exp_busy}) begin
                errors++;
                $display("FAIL rr_drain got=%b want=%b", {done, rsp_z, busy}, {exp_done, exp_rsp, exp_busy});
            end
        end
    endtask

    task automatic test_priority();
        bit seen;
        pulse_reset();
        req = 4'b0100; req_x = 4'($urandom); req_y = 4'($urandom);
        tick();
        req = '0;
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            tick();
            if (done != 4'b0000) seen = 1;
        end
        checks++;
        if (!seen || done !== 4'b0100) begin
            errors++;
            $display("FAIL prio_first_done got=%b want=0100", done);
        end
        // Arbiter is IDLE in the done cycle; present both requests now
        req = 4'b0101;
        tick();
        checks++;
        if (ack !== 4'b0001 || grant_id !== 2'd0) begin
            errors++;
            $display("FAIL prio_wrap got ack=%b gid=%0d want 0001 0", ack, grant_id);
        end
        req = 4'b0100;
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            tick();
            if (ack != 4'b0000) seen = 1;
        end
        checks++;
        if (ack !== 4'b0100 || grant_id !== 2'd2) begin
            errors++;
            $display("FAIL prio_second got ack=%b gid=%0d want 0100 2", ack, grant_id);
        end
        req = '0;
        tick(); tick(); tick();
    endtask

    task automatic test_reset_mid();
        pulse_reset();
        req = 4'b0100; req_x = 4'($urandom); req_y = 4'($urandom);
        tick();
        req = '0;
        tick(); tick();
        // rr pointer now at 3; start requester 3 and abandon it
        req = 4'b1000;
        tick();
        checks++;
        if (ack !== 4'b1000) begin
            errors++;
            $display("FAIL mid_ack got=%b want=1000", ack);
        end
        req = '0; rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({ack, done, busy} !== 9'd0) begin
            errors++;
            $display("FAIL mid_reset got ack=%b done=%b busy=%b want all 0", ack, done, busy);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (done !== 4'b0000 || busy !== 1'b0) begin
                errors++;
                $display("FAIL mid_no_done cyc=%0d got done=%b busy=%b want 0000 0", c, done, busy);
            end
        end
        req = 4'b1001;
        tick();
        checks++;
        if (ack !== 4'b0001 || grant_id !== 2'd0) begin
            errors++;
            $display("FAIL mid_regrant got ack=%b gid=%0d want 0001 0", ack, grant_id);
        end
        req = '0;
        tick(); tick(); tick();
    endtask

    task automatic test_random();
        pulse_reset();
        for (int c = 0; c < 120; c++) begin
            req   = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
            req_x = 4'($urandom);
            req_y = 4'($urandom);
            tick();
            checks++;
            if ({ack, done, busy, grant_id, rsp_z, gate_x, gate_y} !==
                {exp_ack, exp_done, exp_busy, exp_gid, exp_rsp, exp_gx, exp_gy}) begin
                errors++;
                $display("FAIL rand_model cyc=%0d req=%b got=%b want=%b", c, req,
                         {ack, done, busy, grant_id, rsp_z, gate_x, gate_y},
                         {exp_ack, exp_done, exp_busy, exp_gid, exp_rsp, exp_gx, exp_gy});
            end
        end
        req = '0;
        tick(); tick(); tick();
    endtask

`ifdef GATE_ARB_STATS_EN
    task automatic test_stats();
        logic [7:0] model_cnt;
        pulse_reset();
        for (int n = 0; n < 5; n++) begin
            req = 4'b0010; req_x = 4'($urandom); req_y = 4'($urandom);
            tick();
            req = '0;
            tick(); tick();
        end
        checks++;
        if (grant_cnt !== 8'b0000_1100) begin
            errors++;
            $display("FAIL stats_sat got=%b want=00001100", grant_cnt);
        end
        model_cnt = {2'(m_cnt[3]), 2'(m_cnt[2]), 2'(m_cnt[1]), 2'(m_cnt[0])};
        checks++;
        if (grant_cnt !== model_cnt) begin
            errors++;
            $display("FAIL stats_model got=%b want=%b", grant_cnt, model_cnt);
        end
        pulse_reset();
        #1;
        checks++;
        if (grant_cnt !== 8'd0) begin
            errors++;
            $display("FAIL stats_clear got=%b want=0", grant_cnt);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_priority();
        test_reset_mid();
        test_random();
`ifdef GATE_ARB_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
